// File: rtl/timer_int_pkg.sv
// Register map and address decode shared by the timer interrupt controller.
package timer_int_pkg;

    localparam logic [31:0] TIER_OFF  = 32'h14;
    localparam logic [31:0] TISR_OFF  = 32'h18;
    localparam logic [31:0] TMODE_OFF = 32'h1C;
    localparam logic [31:0] CH_BASE   = 32'h40;
    localparam logic [31:0] CH_STRIDE = 32'h10;

    localparam logic [3:0] CMP_LO_OFF = 4'h0;
    localparam logic [3:0] CMP_HI_OFF = 4'h4;
    localparam logic [3:0] PERIOD_OFF = 4'h8;

    typedef enum logic [1:0] {
        SUB_CMP_LO,
        SUB_CMP_HI,
        SUB_PERIOD,
        SUB_RSVD
    } sub_e;

    typedef struct packed {
        logic       vld;
        logic [2:0] ch;
        sub_e       sub;
    } ch_sel_t;

    // Only word-aligned offsets inside an implemented channel block decode as valid.
    function automatic ch_sel_t decode_ch(input logic [31:0] addr, input int unsigned num_ch);
        logic [31:0] off;
        ch_sel_t     sel;
        off     = addr - CH_BASE;
        sel.vld = (addr >= CH_BASE) && (off < num_ch * CH_STRIDE) && (addr[1:0] == 2'b00);
        sel.ch  = off[6:4];
        case (off[3:0])
            CMP_LO_OFF: sel.sub = SUB_CMP_LO;
            CMP_HI_OFF: sel.sub = SUB_CMP_HI;
            PERIOD_OFF: sel.sub = SUB_PERIOD;
            default:    sel.sub = SUB_RSVD;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/timer_int_ch.sv
// One compare channel: compare/period registers, edge-detected match event
// and periodic auto-reload.
module timer_int_ch
    import timer_int_pkg::*;
#(
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CNT_W-1:0] cnt,
    input  logic             periodic,
    input  logic             wr_lo,
    input  logic             wr_hi,
    input  logic             wr_per,
    input  logic [31:0]      wdata,
    output logic [CNT_W-1:0] cmp,
    output logic [31:0]      period,
    output logic             evt
);

    logic [CNT_W-1:0] cmp_q, cmp_d;
    logic [31:0]      period_q, period_d;
    logic             match_q, match_d;
    logic             hit;

    assign hit    = (cnt == cmp_q);
    assign evt    = hit & ~match_q;
    assign cmp    = cmp_q;
    assign period = period_q;

    always_comb begin
        cmp_d    = cmp_q;
        period_d = period_q;
        match_d  = hit;
        if (evt && periodic && (period_q != 32'h0)) begin
            cmp_d = cmp_q + {{(CNT_W-32){1'b0}}, period_q};
        end
        // A software write to one half discards the reload entirely, so the
        // other half keeps its pre-reload value.
        if (wr_lo || wr_hi) begin
            cmp_d   = cmp_q;
            match_d = 1'b0;
        end
        if (wr_lo) begin
            cmp_d[31:0] = wdata;
        end
        if (wr_hi) begin
            cmp_d[CNT_W-1:32] = wdata[CNT_W-33:0];
        end
        if (wr_per) begin
            period_d = wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmp_q    <= '1;
            period_q <= '0;
            match_q  <= 1'b0;
        end else begin
            cmp_q    <= cmp_d;
            period_q <= period_d;
            match_q  <= match_d;
        end
    end

endmodule

// File: rtl/timer_int_ctrl.sv
// Multi-channel compare/interrupt controller: global IER/ISR/MODE registers,
// register decode and read mux, per-channel compare blocks and interrupt OR.
module timer_int_ctrl
    import timer_int_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    input  logic [CNT_W-1:0]  cnt,
    output logic [31:0]       rdata,
    output logic [NUM_CH-1:0] ch_irq,
    output logic              tim_int
);

    logic [NUM_CH-1:0] ier_q, ier_d;
    logic [NUM_CH-1:0] isr_q, isr_d;
    logic [NUM_CH-1:0] mode_q, mode_d;
    logic [NUM_CH-1:0] ch_evt;
    logic [NUM_CH-1:0] wr_lo, wr_hi, wr_per;
    logic [CNT_W-1:0]  ch_cmp [NUM_CH];
    logic [31:0]       ch_per [NUM_CH];
    ch_sel_t           sel;

    assign sel = decode_ch(addr, NUM_CH);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign wr_lo[g]  = wr_en && sel.vld && (sel.ch == 3'(g)) && (sel.sub == SUB_CMP_LO);
        assign wr_hi[g]  = wr_en && sel.vld && (sel.ch == 3'(g)) && (sel.sub == SUB_CMP_HI);
        assign wr_per[g] = wr_en && sel.vld && (sel.ch == 3'(g)) && (sel.sub == SUB_PERIOD);

        timer_int_ch #(.CNT_W(CNT_W)) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .cnt      (cnt),
            .periodic (mode_q[g]),
            .wr_lo    (wr_lo[g]),
            .wr_hi    (wr_hi[g]),
            .wr_per   (wr_per[g]),
            .wdata    (wdata),
            .cmp      (ch_cmp[g]),
            .period   (ch_per[g]),
            .evt      (ch_evt[g])
        );
    end

    always_comb begin
        ier_d  = ier_q;
        mode_d = mode_q;
        isr_d  = isr_q;
        if (wr_en && (addr == TIER_OFF)) begin
            ier_d = wdata[NUM_CH-1:0];
        end
        if (wr_en && (addr == TMODE_OFF)) begin
            mode_d = wdata[NUM_CH-1:0];
        end
        if (wr_en && (addr == TISR_OFF)) begin
            isr_d = isr_q & ~wdata[NUM_CH-1:0];
        end
        // Set after clear so a match coinciding with W1C is never lost.
        isr_d = isr_d | ch_evt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ier_q  <= '0;
            isr_q  <= '0;
            mode_q <= '0;
        end else begin
            ier_q  <= ier_d;
            isr_q  <= isr_d;
            mode_q <= mode_d;
        end
    end

    always_comb begin
        rdata = '0;
        case (addr)
            TIER_OFF:  rdata[NUM_CH-1:0] = ier_q;
            TISR_OFF:  rdata[NUM_CH-1:0] = isr_q;
            TMODE_OFF: rdata[NUM_CH-1:0] = mode_q;
            default:   ;
        endcase
        if (sel.vld) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (sel.ch == i[2:0]) begin
                    case (sel.sub)
                        SUB_CMP_LO: rdata                = ch_cmp[i][31:0];
                        SUB_CMP_HI: rdata[CNT_W-33:0]    = ch_cmp[i][CNT_W-1:32];
                        SUB_PERIOD: rdata                = ch_per[i];
                        default:    rdata                = '0;
                    endcase
                end
            end
        end
    end

    assign ch_irq  = ier_q & isr_q;
    assign tim_int = |ch_irq;

endmodule

// File: doc/timer_int_ctrl.md
# timer_int_ctrl

Multi-channel compare/interrupt controller for the APB timer, replacing the single-channel enable/status logic. It compares the free-running 64-bit counter against NUM_CH independent compare values. It latches per-channel status and raises a combined interrupt line to the RISC-V core. Channels can be one-shot or periodic; in periodic mode the compare value auto-reloads by a per-channel period.

## Interface
- NUM_CH, 4: number of compare channels, 1..8
- CNT_W, 64: counter/compare width, 33..64; compare is written as LO/HI 32-bit words
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- wr_en  in  1  register write strobe from APB slave, one cycle per write
- addr  in  32  byte offset of register access
- wdata  in  32  write data
- cnt  in  CNT_W  current timer counter value
- rdata  out  32  combinational read data for addr; 0 for unmapped offsets
- ch_irq  out  NUM_CH  per-channel interrupt, ier[i] & isr[i]
- tim_int  out  1  OR of ch_irq

## Operation
- Global registers:
  - 0x14 IER: bit i enables channel i; reset 0.
  - 0x18 ISR: bit i is channel i status, write-1-to-clear; reset 0.
  - 0x1C MODE: bit i = 1 selects periodic mode for channel i; reset 0.
  - Bits at or above NUM_CH read 0 and ignore writes.
- Per-channel block at 0x40 + 0x10*i: +0x0 CMP_LO, +0x4 CMP_HI (only bits CNT_W-33..0 used, upper bits read 0), +0x8 PERIOD (32-bit), +0xC reserved (reads 0).
- Reset values: CMP = all ones, PERIOD = 0.
- Match detection:
  - hit[i] = (cnt == cmp[i]).
  - A registered match_q[i] holds the previous hit[i].
  - A match event is hit[i] & ~match_q[i], so a stalled counter parked on the compare value sets status only once.
- On a match event: isr[i] is set. This happens regardless of IER; IER only gates ch_irq.
- Periodic mode with PERIOD != 0: on a match event, cmp[i] <= cmp[i] + PERIOD, zero-extended, modulo 2^CNT_W (wraps past all ones).
- Periodic mode with PERIOD == 0: no reload; behaves as one-shot.
- Simultaneous events on the same channel in the same cycle:
  - W1C of isr[i] with a match event: set wins, so no event is lost.
  - Software write to CMP_LO/CMP_HI with a periodic reload: the software write wins for the written half. The other half keeps its pre-reload value.
- Writing a CMP word clears match_q[i]. A compare written equal to the current cnt therefore produces an event on the next cycle.
- ISR writes with wdata bit = 0 have no effect on that bit.

## Timing
- All register writes take effect at the rising clk edge on which wr_en is high.
- Match latency: if cnt == cmp[i] is sampled at edge N, isr[i] is 1 after edge N, and ch_irq[i] and tim_int are high in the same cycle.
- A periodic reload is visible in CMP reads after edge N.
- W1C latency: the ISR bit reads 0, and ch_irq drops, in the cycle after the write edge.
- rdata is purely combinational from addr and the current register state; there is no read side effect.
- Reset: the asynchronous assert clears IER, ISR, MODE and match_q, sets CMP to all ones, and clears PERIOD. ch_irq and tim_int are then 0 immediately. Reset released mid-count resumes with no pending events.

## Structure
- Package timer_int_pkg holds:
  - the offset constants TIER_OFF 0x14, TISR_OFF 0x18, TMODE_OFF 0x1C, CH_BASE 0x40, CH_STRIDE 0x10, CMP_LO/CMP_HI/PERIOD sub-offsets;
  - a function decoding addr into channel index and sub-register.
- Sub-module timer_int_ch, instantiated NUM_CH times. It contains cmp, period, match_q, the reload adder and the event output, and receives its mode bit and decoded write strobes.
- The top level contains IER/ISR/MODE, address decode, the rdata mux and the interrupt OR.

## Test plan
- One-shot: NUM_CH=4, write CMP0 = 0x100, IER = 0x1. Step cnt from 0xF0 -> isr[0] and tim_int rise in the cycle after cnt = 0x100. Write ISR = 0x1 -> both drop next cycle, with no re-set while cnt is held at 0x100.
- Periodic wrap: MODE = 0x2, CMP1 = 0xFFFF_FFFF_FFFF_FFF0, PERIOD1 = 0x20. On the match -> CMP1 reads 0x0000_0000_0000_0010. Wrap cnt to 0x10 -> second event fires.
- Masking: with IER = 0, a channel-2 match -> ISR = 0x4, tim_int 0. Write IER = 0x4 -> tim_int = 1 next cycle.
- Set/clear collision: a W1C of bit 3 in the same cycle as a channel-3 match event -> isr[3] stays 1.
- Multi-channel: CMP0 = CMP2 = 0x50 -> both bits set in the same cycle, ch_irq = 0x5. Clear bit 0 only -> ch_irq = 0x4, tim_int stays 1.
- Reset: assert rst_n low mid-operation with ISR = 0xF -> outputs 0 asynchronously, CMP reads all ones, PERIOD reads 0.
